// File: rtl/sub_mp_seq.sv
// Word-serial multi-precision subtract sequencer: streams WORDS 32-bit slices through an
// external sub unit, LS word first, chaining each borrow-out into the next borrow-in.
module sub_mp_seq #(
    parameter int WORDS = 4,
    parameter int CNT_W = $clog2(WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDS*32-1:0]   op_a,
    input  logic [WORDS*32-1:0]   op_b,
    input  logic                  bin_i,
    output logic                  sub_en,
    output logic [31:0]           sub_a,
    output logic [31:0]           sub_b,
    output logic                  sub_bin,
    input  logic [31:0]           sub_result,
    input  logic                  sub_bout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORDS*32-1:0]   res_data,
    output logic                  res_bout,
    output logic                  res_zero,
    output logic                  busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic                     borrow_q, borrow_d;
    logic [WORDS-1:0][31:0]   a_q, a_d;
    logic [WORDS-1:0][31:0]   b_q, b_d;
    logic [WORDS-1:0][31:0]   res_q, res_d;
    logic                     res_bout_q, res_bout_d;
    logic                     res_zero_q, res_zero_d;

    logic [IDX_W-1:0]         widx;
    logic                     last_word;

    // idx reaches WORDS after the final RUN edge; only the low bits select a word,
    // and word selection is only consumed while in RUN (idx <= WORDS-1 there).
    assign widx      = idx_q[IDX_W-1:0];
    assign last_word = (idx_q == CNT_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)  state_d = RUN;
            RUN:  if (last_word) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        sub_en    = 1'b0;
        sub_a     = '0;
        sub_b     = '0;
        sub_bin   = 1'b0;
        if (state_q == RUN) begin
            sub_en  = 1'b1;
            sub_a   = a_q[widx];
            sub_b   = b_q[widx];
            sub_bin = borrow_q;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        borrow_d   = borrow_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        res_bout_d = res_bout_q;
        res_zero_d = res_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    borrow_d = bin_i;
                    idx_d    = '0;
                end
            end
            RUN: begin
                res_d[widx] = sub_result;
                borrow_d    = sub_bout;
                idx_d       = idx_q + CNT_W'(1);
                // Zero flag is taken over the fully assembled result, including this word.
                if (last_word) begin
                    res_bout_d = sub_bout;
                    res_zero_d = (res_d == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            res_bout_q <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            borrow_q   <= borrow_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            res_bout_q <= res_bout_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign res_data = res_q;
    assign res_bout = res_bout_q;
    assign res_zero = res_zero_q;

endmodule

// File: tb/tb_sub_mp_seq.sv
// Bench for sub_mp_seq with WORDS=2: behavioural 32-bit sub unit, 65-bit reference
// model feeding a result queue, directed corner cases then randomised traffic.
module tb_sub_mp_seq;

    localparam int WORDS = 2;
    localparam int W     = WORDS * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a, op_b;
    logic          bin_i;
    logic          sub_en;
    logic [31:0]   sub_a, sub_b;
    logic          sub_bin;
    logic [31:0]   sub_result;
    logic          sub_bout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res_data;
    logic          res_bout;
    logic          res_zero;
    logic          busy;

    typedef struct packed {
        logic [W-1:0] res;
        logic         bout;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    // External sub unit: combinational, outputs zero while disabled.
    logic [32:0] sub_full;
    assign sub_full   = sub_en ? ({1'b0, sub_a} - {1'b0, sub_b} - {32'b0, sub_bin}) : 33'b0;
    assign sub_result = sub_full[31:0];
    assign sub_bout   = sub_full[32];

    sub_mp_seq #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .bin_i      (bin_i),
        .sub_en     (sub_en),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_bin    (sub_bin),
        .sub_result (sub_result),
        .sub_bout   (sub_bout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_data   (res_data),
        .res_bout   (res_bout),
        .res_zero   (res_zero),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] full;
        exp_t e;
        full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.res  = full[W-1:0];
        e.bout = full[W];
        e.zero = (full[W-1:0] == '0);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge of RUN cycle 1.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                            input bit push);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", W'(in_ready), W'(1));
        op_a     = a;
        op_b     = b;
        bin_i    = bin;
        in_valid = 1'b1;
        if (push) exp_q.push_back(model(a, b, bin));
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
    endtask

    task automatic finish_op(input int stall);
        int   n = 0;
        exp_t e;
        logic [W-1:0] snap_d;
        logic snap_b, snap_z;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", W'(out_valid), W'(1));
        snap_d = res_data;
        snap_b = res_bout;
        snap_z = res_zero;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_data", res_data, snap_d);
            check("stall_flags", W'({res_bout, res_zero}), W'({snap_b, snap_z}));
            check("stall_valid_ready", W'({out_valid, in_ready}), W'(2'b10));
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", W'(exp_q.size()), W'(1));
        end else begin
            e = exp_q.pop_front();
            check("res_data", res_data, e.res);
            check("res_bout", W'(res_bout), W'(e.bout));
            check("res_zero", W'(res_zero), W'(e.zero));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_handshake_idle", W'({out_valid, in_ready, busy}), W'(3'b010));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        bin_i     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready_valid_busy", W'({in_ready, out_valid, busy}), W'(3'b100));
        check("rst_res_data", res_data, '0);
        check("rst_res_flags", W'({res_bout, res_zero}), W'(0));
        check("rst_sub_outputs", W'({sub_en, sub_a, sub_b, sub_bin}), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Borrow from word0 into word1, with per-cycle latency and chain checks.
        start_op(64'h0000_0001_0000_0000, 64'h1, 1'b0, 1'b1);
        check("run1_sub_en", W'({sub_en, out_valid, in_ready, busy}), W'(4'b1001));
        check("run1_word0", W'({sub_a, sub_b, sub_bin}), W'({32'h0, 32'h1, 1'b0}));
        op_a     = '1;
        op_b     = '0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("run2_sub_en", W'({sub_en, out_valid, in_ready}), W'(3'b100));
        check("run2_word1", W'({sub_a, sub_b, sub_bin}), W'({32'h1, 32'h0, 1'b1}));
        @(negedge clk);
        check("done_sub_off", W'({sub_en, out_valid, in_ready}), W'(3'b010));
        finish_op(0);
        repeat (4) @(negedge clk);
        check("ignored_req_not_queued", W'({out_valid, busy}), W'(0));

        start_op(64'h0, 64'h1, 1'b0, 1'b1);
        finish_op(0);
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        finish_op(0);
        start_op(64'h5, 64'h5, 1'b1, 1'b1);
        finish_op(0);

        // Backpressure for 10 cycles.
        start_op(64'hDEAD_BEEF_0000_0010, 64'h0000_0001_0000_0020, 1'b1, 1'b1);
        finish_op(10);

        // Reset during RUN cycle 1 discards the operation.
        start_op(64'h7, 64'h3, 1'b0, 1'b0);
        check("pre_reset_sub_en", W'(sub_en), W'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_midrun_idle", W'({sub_en, busy, out_valid, in_ready}), W'(4'b0001));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_midrun_no_valid", W'({out_valid, busy}), W'(0));
        end

        // Randomised traffic with sporadic consumer stalls.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = '0;
                2: b = '1;
                3: a[31:0] = b[31:0];
                default: ;
            endcase
            start_op(a, b, 1'($urandom_range(0, 1)), 1'b1);
            finish_op(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        check("scoreboard_drained", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
